// File: rtl/cla_sub_seq_if.sv
// Handshake bundle for the sequential borrow-lookahead subtractor.
// The master drives operands and out_ready; the slave is the subtractor.
interface cla_sub_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, d, bout, ovf
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, d, bout, ovf
    );
endinterface

// File: rtl/cla_sub_seq.sv
// Multi-cycle subtractor d = a - b - bin, one 4-bit lookahead slice per clock,
// LSB slice first; results are held until the consumer takes them.
module cla_sub_seq #(
    parameter int WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    cla_sub_seq_if.slave bus
);
    localparam int NSLICE = WIDTH / 4;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic               bout_q, bout_d;
    logic               ovf_q, ovf_d;

    logic [3:0]         a_nib;
    logic [3:0]         b_nib;
    logic [4:0]         slice;
    logic [WIDTH-1:0]   res_slice;
    logic               last_slice;

    // 4-bit lookahead add; returns {carry_out, sum}
    function automatic logic [4:0] cla4_slice(input logic [3:0] x,
                                              input logic [3:0] y,
                                              input logic       cin);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = x & y;
        p    = x ^ y;
        c[0] = cin;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        return {c[4], p ^ c[3:0]};
    endfunction

    always_comb begin
        a_nib     = '0;
        b_nib     = '0;
        res_slice = res_q;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_nib = a_q[4*i +: 4];
                b_nib = b_q[4*i +: 4];
            end
        end
        // Subtraction as a + ~b + carry, where carry starts as ~bin
        slice = cla4_slice(a_nib, ~b_nib, carry_q);
        for (int i = 0; i < NSLICE; i++) begin
            if (idx_q == IDX_W'(i)) begin
                res_slice[4*i +: 4] = slice[3:0];
            end
        end
        last_slice = (idx_q == IDX_W'(NSLICE - 1));
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        res_d   = res_q;
        d_d     = d_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = ~bus.bin;
                    idx_d   = '0;
                    res_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d   = res_slice;
                carry_d = slice[4];
                if (last_slice) begin
                    d_d     = res_slice;
                    bout_d  = ~slice[4];
                    ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                              (res_slice[WIDTH-1] != a_q[WIDTH-1]);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            res_q   <= '0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Handshake flags decode registered state only
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.d         = d_q;
    assign bus.bout      = bout_q;
    assign bus.ovf       = ovf_q;

endmodule
